// File: rtl/bram_arb_pkg.sv
// Shared types and default region geometry for the NSK/VSK BRAM write arbiter.
package bram_arb_pkg;

  typedef enum logic [1:0] {IDLE, G_NSK, G_VSK} arb_state_t;

  localparam logic SRC_NSK = 1'b0;
  localparam logic SRC_VSK = 1'b1;

  localparam int NSK_BASE      = 0;
  localparam int NSK_DEPTH_DEF = 2048;
  localparam int VSK_DEPTH_DEF = 131072;
  localparam int NSK_LIMIT_DEF = 512;
  localparam int VSK_LIMIT_DEF = 1024;
  localparam int LEN_W         = 11;

  // Round-robin pick in IDLE: 1 selects VSK. Contention goes to whoever was not served last.
  function automatic logic rr_pick_vsk(input logic nsk_valid, input logic vsk_valid,
                                       input logic last_served);
    if (nsk_valid && vsk_valid)
      return last_served == SRC_NSK;
    return vsk_valid;
  endfunction

endpackage

// File: rtl/bram_region_ptr.sv
// Per-channel region state: wrapping write offset, packet word counter and truncation flag.
module bram_region_ptr
  import bram_arb_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int LIMIT = 512,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             clr,
  input  logic             inc,
  input  logic             accept,
  output logic [PTR_W-1:0] ptr,
  output logic [LEN_W-1:0] cnt,
  output logic             room,
  output logic             trunc
);

  logic [PTR_W-1:0] ptr_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic             trunc_reg;

  assign ptr   = ptr_reg;
  assign cnt   = cnt_reg;
  assign trunc = trunc_reg;
  assign room  = cnt_reg < LEN_W'(LIMIT);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      trunc_reg <= 1'b0;
    end else begin
      if (inc)
        ptr_reg <= (ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : ptr_reg + PTR_W'(1);
      // Closing a packet wins over counting: the final word is already folded into pkt_len.
      if (clr) begin
        cnt_reg   <= '0;
        trunc_reg <= 1'b0;
      end else begin
        if (inc)
          cnt_reg <= cnt_reg + LEN_W'(1);
        if (accept && !room)
          trunc_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_wr_arbiter.sv
// Packet-granular arbiter sharing one BRAM write port between the NSK and VSK streams.
// Build option: define VSK_PRIORITY_EN to make VSK win every idle arbitration it is valid for.
module bram_wr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NSK_DEPTH = NSK_DEPTH_DEF,
  parameter int VSK_DEPTH = VSK_DEPTH_DEF,
  parameter int NSK_LIMIT = NSK_LIMIT_DEF,
  parameter int VSK_LIMIT = VSK_LIMIT_DEF,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 18,
  parameter int NSK_PW    = $clog2(NSK_DEPTH),
  parameter int VSK_PW    = $clog2(VSK_DEPTH)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_nsk_valid,
  input  logic [DATA_W-1:0] s_nsk_data,
  input  logic              s_nsk_last,
  output logic              s_nsk_ready,
  input  logic              s_vsk_valid,
  input  logic [DATA_W-1:0] s_vsk_data,
  input  logic              s_vsk_last,
  output logic              s_vsk_ready,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic [NSK_PW-1:0] nsk_wr_ptr,
  output logic [VSK_PW-1:0] vsk_wr_ptr,
  output logic              pkt_done,
  output logic              pkt_src,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              pkt_trunc
);

  arb_state_t state_reg;
  logic       last_served_reg;

  logic [1:0] ch_valid, ch_last, ch_gnt, ch_acc, ch_room, ch_inc, ch_close, ch_trunc;
  logic [LEN_W-1:0] nsk_cnt, vsk_cnt;

  assign ch_valid = {s_vsk_valid, s_nsk_valid};
  assign ch_last  = {s_vsk_last, s_nsk_last};
  assign ch_gnt   = {state_reg == G_VSK, state_reg == G_NSK};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      assign ch_acc[gi]   = ch_valid[gi] & ch_gnt[gi];
      assign ch_inc[gi]   = ch_acc[gi] & ch_room[gi];
      assign ch_close[gi] = ch_acc[gi] & ch_last[gi];
    end
  endgenerate

  // Ready comes straight from the state register, so IDLE costs exactly one bubble per packet.
  assign s_nsk_ready = ch_gnt[0];
  assign s_vsk_ready = ch_gnt[1];

  bram_region_ptr #(.DEPTH(NSK_DEPTH), .LIMIT(NSK_LIMIT), .PTR_W(NSK_PW)) u_nsk_ptr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (ch_close[0]),
    .inc     (ch_inc[0]),
    .accept  (ch_acc[0]),
    .ptr     (nsk_wr_ptr),
    .cnt     (nsk_cnt),
    .room    (ch_room[0]),
    .trunc   (ch_trunc[0])
  );

  bram_region_ptr #(.DEPTH(VSK_DEPTH), .LIMIT(VSK_LIMIT), .PTR_W(VSK_PW)) u_vsk_ptr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (ch_close[1]),
    .inc     (ch_inc[1]),
    .accept  (ch_acc[1]),
    .ptr     (vsk_wr_ptr),
    .cnt     (vsk_cnt),
    .room    (ch_room[1]),
    .trunc   (ch_trunc[1])
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg       <= IDLE;
      last_served_reg <= SRC_VSK;
    end else begin
      case (state_reg)
        IDLE: begin
`ifdef VSK_PRIORITY_EN
          if (s_vsk_valid)
            state_reg <= G_VSK;
          else if (s_nsk_valid)
            state_reg <= G_NSK;
`else
          if (|ch_valid)
            state_reg <= rr_pick_vsk(s_nsk_valid, s_vsk_valid, last_served_reg) ? G_VSK : G_NSK;
`endif
        end
        G_NSK: if (ch_close[0]) begin
          state_reg       <= IDLE;
          last_served_reg <= SRC_NSK;
        end
        G_VSK: if (ch_close[1]) begin
          state_reg       <= IDLE;
          last_served_reg <= SRC_VSK;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic              en_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] din_reg;
  logic              done_reg, src_reg, trunc_reg;
  logic [LEN_W-1:0]  len_reg;

  assign bram_en   = en_reg;
  assign bram_we   = {4{en_reg}};
  assign bram_addr = addr_reg;
  assign bram_din  = din_reg;
  assign pkt_done  = done_reg;
  assign pkt_src   = src_reg;
  assign pkt_len   = len_reg;
  assign pkt_trunc = trunc_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_reg    <= 1'b0;
      addr_reg  <= '0;
      din_reg   <= '0;
      done_reg  <= 1'b0;
      src_reg   <= 1'b0;
      len_reg   <= '0;
      trunc_reg <= 1'b0;
    end else begin
      en_reg    <= 1'b0;
      addr_reg  <= '0;
      din_reg   <= '0;
      done_reg  <= 1'b0;
      src_reg   <= 1'b0;
      len_reg   <= '0;
      trunc_reg <= 1'b0;
      if (ch_inc[0]) begin
        en_reg   <= 1'b1;
        addr_reg <= ADDR_W'(NSK_BASE) + ADDR_W'(nsk_wr_ptr);
        din_reg  <= s_nsk_data;
      end else if (ch_inc[1]) begin
        en_reg   <= 1'b1;
        addr_reg <= ADDR_W'(NSK_DEPTH) + ADDR_W'(vsk_wr_ptr);
        din_reg  <= s_vsk_data;
      end
      // The close pulse lines up with the final write; a dropped last still closes on its own.
      if (ch_close[0]) begin
        done_reg  <= 1'b1;
        src_reg   <= SRC_NSK;
        len_reg   <= nsk_cnt + LEN_W'(ch_inc[0]);
        trunc_reg <= ch_trunc[0] | ~ch_room[0];
      end else if (ch_close[1]) begin
        done_reg  <= 1'b1;
        src_reg   <= SRC_VSK;
        len_reg   <= vsk_cnt + LEN_W'(ch_inc[1]);
        trunc_reg <= ch_trunc[1] | ~ch_room[1];
      end
    end
  end

endmodule

// File: tb/tb_bram_wr_arbiter.sv
// Bench for bram_wr_arbiter: packet-level reference model checked every cycle plus directed literals.
module tb_bram_wr_arbiter;

  localparam int NSK_DEPTH = 2048;
  localparam int VSK_DEPTH = 131072;
  localparam int NSK_LIMIT = 512;
  localparam int VSK_LIMIT = 1024;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        s_nsk_valid = 1'b0, s_nsk_last = 1'b0, s_nsk_ready;
  logic [31:0] s_nsk_data = '0;
  logic        s_vsk_valid = 1'b0, s_vsk_last = 1'b0, s_vsk_ready;
  logic [31:0] s_vsk_data = '0;
  logic        bram_en, pkt_done, pkt_src, pkt_trunc;
  logic [3:0]  bram_we;
  logic [17:0] bram_addr;
  logic [31:0] bram_din;
  logic [10:0] nsk_wr_ptr, pkt_len;
  logic [16:0] vsk_wr_ptr;

  always #5 aclk = ~aclk;

  bram_wr_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_nsk_valid(s_nsk_valid), .s_nsk_data(s_nsk_data), .s_nsk_last(s_nsk_last), .s_nsk_ready(s_nsk_ready),
    .s_vsk_valid(s_vsk_valid), .s_vsk_data(s_vsk_data), .s_vsk_last(s_vsk_last), .s_vsk_ready(s_vsk_ready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .nsk_wr_ptr(nsk_wr_ptr), .vsk_wr_ptr(vsk_wr_ptr),
    .pkt_done(pkt_done), .pkt_src(pkt_src), .pkt_len(pkt_len), .pkt_trunc(pkt_trunc)
  );

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt[2] = '{0, 0};

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int src; int len; int trunc; } pkt_t;
  wr_t  wr_q[$];
  pkt_t pkt_q[$];

`ifdef VSK_PRIORITY_EN
  int t2_addr[8] = '{2048, 2049, 2050, 2051, 0, 1, 2, 3};
  int t2_src[4]  = '{1, 1, 0, 0};
  int t5_src     = 1;
  int t5_addr    = 2048;
`else
  int t2_addr[8] = '{0, 1, 2048, 2049, 2, 3, 2050, 2051};
  int t2_src[4]  = '{0, 1, 0, 1};
  int t5_src     = 0;
  int t5_addr    = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: which channel holds the port, region offsets, words this packet.
  int m_gnt = -1;
  int m_last = 1;
  int m_ptr[2] = '{0, 0};
  int m_cnt[2] = '{0, 0};
  int m_tr[2]  = '{0, 0};
  int e_en = 0, e_addr = 0, e_din = 0, e_done = 0, e_src = 0, e_len = 0, e_trunc = 0;

  function automatic int depth_of(input int c); return c == 0 ? NSK_DEPTH : VSK_DEPTH; endfunction
  function automatic int limit_of(input int c); return c == 0 ? NSK_LIMIT : VSK_LIMIT; endfunction
  function automatic int base_of(input int c);  return c == 0 ? 0 : NSK_DEPTH; endfunction

  initial begin
    int c;
    bit v0, v1, vc, lc;
    int dc;
    forever begin
      @(posedge aclk or negedge aresetn);
      e_en = 0; e_addr = 0; e_din = 0; e_done = 0; e_src = 0; e_len = 0; e_trunc = 0;
      if (!aresetn) begin
        m_gnt = -1; m_last = 1;
        m_ptr = '{0, 0}; m_cnt = '{0, 0}; m_tr = '{0, 0};
      end else if (m_gnt < 0) begin
        v0 = s_nsk_valid; v1 = s_vsk_valid;
`ifdef VSK_PRIORITY_EN
        if (v1) m_gnt = 1; else if (v0) m_gnt = 0;
`else
        if (v0 && v1) m_gnt = 1 - m_last; else if (v0) m_gnt = 0; else if (v1) m_gnt = 1;
`endif
      end else begin
        c  = m_gnt;
        vc = (c == 0) ? s_nsk_valid : s_vsk_valid;
        lc = (c == 0) ? s_nsk_last : s_vsk_last;
        dc = (c == 0) ? int'(s_nsk_data) : int'(s_vsk_data);
        if (vc) begin
          if (m_cnt[c] < limit_of(c)) begin
            e_en = 1; e_addr = base_of(c) + m_ptr[c]; e_din = dc;
            m_ptr[c] = (m_ptr[c] + 1) % depth_of(c);
            m_cnt[c]++;
          end else begin
            m_tr[c] = 1;
          end
          if (lc) begin
            e_done = 1; e_src = c; e_len = m_cnt[c]; e_trunc = m_tr[c];
            m_cnt[c] = 0; m_tr[c] = 0; m_last = c; m_gnt = -1;
          end
        end
      end
    end
  end

  // Every-cycle comparison plus transaction recording.
  initial begin
    forever begin
      @(negedge aclk);
      chk("bram_en", bram_en, e_en);
      chk("bram_we", bram_we, e_en != 0 ? 32'hF : 32'h0);
      chk("bram_addr", bram_addr, e_addr);
      chk("bram_din", bram_din, e_din);
      chk("pkt_done", pkt_done, e_done);
      chk("pkt_src", pkt_src, e_src);
      chk("pkt_len", pkt_len, e_len);
      chk("pkt_trunc", pkt_trunc, e_trunc);
      chk("s_nsk_ready", s_nsk_ready, (m_gnt == 0) ? 1 : 0);
      chk("s_vsk_ready", s_vsk_ready, (m_gnt == 1) ? 1 : 0);
      chk("nsk_wr_ptr", nsk_wr_ptr, m_ptr[0]);
      chk("vsk_wr_ptr", vsk_wr_ptr, m_ptr[1]);
      if (bram_en === 1'b1) wr_q.push_back('{int'(bram_addr), int'(bram_din)});
      if (pkt_done === 1'b1) begin
        pkt_q.push_back('{int'(pkt_src), int'(pkt_len), int'(pkt_trunc)});
        $display("pkt_done src=%0d len=%0d trunc=%0d t=%0t", pkt_src, pkt_len, pkt_trunc, $time);
      end
    end
  end

  task automatic drive(input int ch, input logic v, input logic [31:0] d, input logic l);
    if (ch == 0) begin s_nsk_valid = v; s_nsk_data = d; s_nsk_last = l; end
    else         begin s_vsk_valid = v; s_vsk_data = d; s_vsk_last = l; end
  endtask

  task automatic send_pkt(input int ch, input int n, input int d0, input bit with_last);
    int  waited;
    bit  rdy;
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      drive(ch, 1'b1, 32'(d0 + i), with_last && (i == n - 1));
      waited = 0;
      forever begin
        rdy = (ch == 0) ? s_nsk_ready : s_vsk_ready;
        @(posedge aclk);
        if (rdy) break;
        waited++;
        if (waited > 3000) begin
          n_checks++; n_errors++;
          $display("FAIL handshake_timeout ch=%0d word=%0d: got no ready, required ready within 3000 cycles", ch, i);
          return;
        end
        @(negedge aclk);
      end
      acc_cnt[ch]++;
    end
  endtask

  task automatic rel(input int ch);
    @(negedge aclk);
    drive(ch, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic pulse_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    idle(2);
    aresetn = 1'b1;
  endtask

  initial begin
    int a0;
    #1 aresetn = 1'b0;
    idle(3);
    chk("reset_bram_en", bram_en, 0);
    chk("reset_nsk_ptr", nsk_wr_ptr, 0);
    aresetn = 1'b1;
    idle(2);

    // 1: single NSK packet of 4 words
    wr_q.delete(); pkt_q.delete();
    send_pkt(0, 4, 32'hA0, 1'b1); rel(0); idle(3);
    chk("t1_nwrites", wr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      chk("t1_addr", wr_q[i].addr, i);
      chk("t1_data", wr_q[i].data, 32'hA0 + i);
    end
    chk("t1_npkts", pkt_q.size(), 1);
    if (pkt_q.size() > 0) begin
      chk("t1_src", pkt_q[0].src, 0);
      chk("t1_len", pkt_q[0].len, 4);
      chk("t1_trunc", pkt_q[0].trunc, 0);
    end
    chk("t1_nsk_ptr", nsk_wr_ptr, 4);

    // 2: both channels, back-to-back 2-word packets from reset
    pulse_reset();
    wr_q.delete(); pkt_q.delete();
    fork
      begin send_pkt(0, 2, 32'hB0, 1'b1); send_pkt(0, 2, 32'hB2, 1'b1); rel(0); end
      begin send_pkt(1, 2, 32'hC0, 1'b1); send_pkt(1, 2, 32'hC2, 1'b1); rel(1); end
    join
    idle(3);
    chk("t2_nwrites", wr_q.size(), 8);
    for (int i = 0; i < 8 && i < wr_q.size(); i++) chk("t2_addr", wr_q[i].addr, t2_addr[i]);
    chk("t2_npkts", pkt_q.size(), 4);
    for (int i = 0; i < 4 && i < pkt_q.size(); i++) chk("t2_src", pkt_q[i].src, t2_src[i]);

    // 3: oversize VSK packet, 1030 words against a 1024 limit
    wr_q.delete(); pkt_q.delete();
    a0 = acc_cnt[1];
    send_pkt(1, 1030, 32'h3000_0000, 1'b1); rel(1); idle(3);
    chk("t3_accepted", acc_cnt[1] - a0, 1030);
    chk("t3_nwrites", wr_q.size(), 1024);
    if (wr_q.size() > 0) begin
      chk("t3_first_addr", wr_q[0].addr, 2052);
      chk("t3_last_addr", wr_q[wr_q.size() - 1].addr, 3075);
      chk("t3_last_data", wr_q[wr_q.size() - 1].data, 32'h3000_03FF);
    end
    chk("t3_npkts", pkt_q.size(), 1);
    if (pkt_q.size() > 0) begin
      chk("t3_src", pkt_q[0].src, 1);
      chk("t3_len", pkt_q[0].len, 1024);
      chk("t3_trunc", pkt_q[0].trunc, 1);
    end
    chk("t3_vsk_ptr", vsk_wr_ptr, 1028);

    // 4: walk NSK pointer to 2046, then wrap with a 4-word packet
    pkt_q.delete();
    send_pkt(0, 512, 32'h1000, 1'b1);
    send_pkt(0, 512, 32'h1200, 1'b1);
    send_pkt(0, 512, 32'h1400, 1'b1);
    send_pkt(0, 506, 32'h1600, 1'b1);
    rel(0); idle(3);
    chk("t4_at_limit_len", pkt_q.size() > 0 ? pkt_q[0].len : -1, 512);
    chk("t4_at_limit_trunc", pkt_q.size() > 0 ? pkt_q[0].trunc : -1, 0);
    chk("t4_preset_ptr", nsk_wr_ptr, 2046);
    wr_q.delete(); pkt_q.delete();
    send_pkt(0, 4, 32'hD0, 1'b1); rel(0); idle(3);
    chk("t4_nwrites", wr_q.size(), 4);
    if (wr_q.size() == 4) begin
      chk("t4_addr0", wr_q[0].addr, 2046);
      chk("t4_addr1", wr_q[1].addr, 2047);
      chk("t4_addr2", wr_q[2].addr, 0);
      chk("t4_addr3", wr_q[3].addr, 1);
    end
    chk("t4_ptr_end", nsk_wr_ptr, 2);
    chk("t4_len", pkt_q.size() > 0 ? pkt_q[0].len : -1, 4);

    // 5: reset in the middle of a VSK packet
    wr_q.delete(); pkt_q.delete();
    send_pkt(1, 10, 32'h5000, 1'b0); rel(1);
    chk("t5_vsk_ptr_before", vsk_wr_ptr, 1038);
    #2 aresetn = 1'b0;
    #1;
    chk("t5_en_in_reset", bram_en, 0);
    chk("t5_vsk_ptr_in_reset", vsk_wr_ptr, 0);
    chk("t5_nsk_ptr_in_reset", nsk_wr_ptr, 0);
    chk("t5_ready_in_reset", s_vsk_ready, 0);
    idle(3);
    aresetn = 1'b1;
    chk("t5_no_pkt_done", pkt_q.size(), 0);
    wr_q.delete();
    fork
      begin send_pkt(0, 2, 32'hE0, 1'b1); rel(0); end
      begin send_pkt(1, 2, 32'hF0, 1'b1); rel(1); end
    join
    idle(3);
    chk("t5_first_src", pkt_q.size() > 0 ? pkt_q[0].src : -1, t5_src);
    chk("t5_first_addr", wr_q.size() > 0 ? wr_q[0].addr : -1, t5_addr);
    chk("t5_nsk_ptr", nsk_wr_ptr, 2);
    chk("t5_vsk_ptr", vsk_wr_ptr, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
